seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Multi-digit seven-segment scan driver. It sits directly downstream of the hex/BCD counter stage.
- Accepts NUM_DIGITS nibbles plus decimal points through a load strobe.
- Double-buffers them so the displayed frame never tears.
- Time-multiplexes them onto one shared segment bus with one-hot digit selects.
- Inserts a blanking dead time between digits and optionally suppresses leading zeros.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 10000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 16, dead-time cycles at the start of each slot (0 <= BLANK_CYCLES < SCAN_DIV)
BLANK_LEADING, 1, 1 = suppress leading zeros; 0 = always show all digits

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  single-cycle strobe; captures digits_in/dp_in into the pending buffer
digits_in  in  4*NUM_DIGITS  nibble i at [4i+3:4i]; digit 0 is least significant
dp_in  in  NUM_DIGITS  decimal point per digit
seg_out  out  7  segments a..g on bits 0..6, active-high
dp_out  out  1  decimal point of the currently selected digit, active-high
dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high
frame_start  out  1  one-cycle pulse on the first cycle of the digit-0 slot

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high on rst.
- Reset values:
  - Outputs: seg_out=0, dp_out=0, dig_sel=0, frame_start=0.
  - Internal: active and pending buffers = 0, pending_valid=0, slot counter=0, digit index=0.
- rst mid-frame: outputs take reset values after the next edge; pending data is discarded.
- Slot timing, measured from the first cycle with rst=0, called cycle 0:
  - Slot k spans cycles k*SCAN_DIV .. k*SCAN_DIV+SCAN_DIV-1.
  - Slot k drives digit index k mod NUM_DIGITS.
  - One frame = NUM_DIGITS*SCAN_DIV cycles. The index wraps NUM_DIGITS-1 -> 0.
- Per-slot state machine:
  - BLANK: the first BLANK_CYCLES cycles of the slot. dig_sel=0, seg_out=0, dp_out=0.
  - DRIVE: the remaining cycles of the slot. dig_sel=1<<idx, seg_out=decode(active[idx]), dp_out=active_dp[idx].
  - BLANK_CYCLES=0 skips BLANK entirely.
- Outputs are registered; the observable timing above is normative. Internal pipelining must be hidden by it.
- frame_start pulses in cycle 0 and then every NUM_DIGITS*SCAN_DIV cycles.
- Buffering and commit:
  - load=1 writes pending <= {digits_in, dp_in} and sets pending_valid.
  - A later load before commit overwrites pending (last write wins).
  - Commit happens on the cycle before each frame_start: if pending_valid, then active <= pending and pending_valid cleared.
  - A load in cycle c appears on the outputs from the first frame_start at cycle >= c+2.
  - A load in the same cycle as a commit goes to pending and is shown the following frame.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i with i>0 is suppressed when active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit gets seg_out=0, but dig_sel is still asserted and dp_out still follows dp_in.
- Decode is hex, active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Counter widths: slot counter uses $clog2(SCAN_DIV) bits and the index uses $clog2(NUM_DIGITS) bits. Both wrap exactly; no off-by-one at SCAN_DIV-1 -> 0.

Decomposition:
- Shared package: segment code constants SEG_0..SEG_F, plus the BLANK/DRIVE state enum.
- One sub-module, hex7_decode: a purely combinational 4-bit nibble to 7-bit segment lookup, instantiated once on the muxed nibble.
- Scan counter, buffers and blanking logic stay in seg_scan_mux.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset then idle, no load:
   - frame_start at cycles 0, 32, 64.
   - dig_sel is 0 for cycles 0-1, 0001 for cycles 2-7, 0 for cycles 8-9, 0010 for cycles 10-15, and so on.
   - seg_out=3F on digit 0 only; digits 1-3 show seg_out=0 (leading-zero blanked).
2. Load digits=16'h1A3F, dp=4'b0100 at cycle 5:
   - Frame 0 is unchanged.
   - From cycle 32: digit 0 drives seg 71, digit 1 drives 4F, digit 2 drives 77 with dp_out=1, digit 3 drives 06.
3. Two loads before a commit, 16'h1111 at cycle 10 then 16'h2222 at cycle 20:
   - Frame from cycle 32 shows all digits as 5B; 06 is never driven.
4. Load at cycle 31 (the commit cycle):
   - Not shown in the frame starting at cycle 32; shown from cycle 64.
5. Load 16'h0070 with BLANK_LEADING=1:
   - Digits 3 and 2 show seg_out=0 with their dig_sel still asserted; digit 1 shows 07; digit 0 shows 3F.
   - With BLANK_LEADING=0, digits 3 and 2 show 3F.
6. Assert rst at cycle 45 for one cycle:
   - Next cycle all outputs are 0 and the active buffer is cleared.
   - Timing restarts with frame_start on the first cycle after rst deasserts.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the seven-segment scan driver: hex segment codes
// (segments a..g on bits 0..6, active-high) and the per-slot phase enum.
package seg_scan_mux_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_mux_hex7_decode.sv
// Combinational hex nibble to seven-segment pattern lookup (active-high).
module hex7_decode
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit seven-segment scan driver: double-buffered digit capture, slot
// timing with blanking dead time, leading-zero suppression and registered outputs.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 10000,
  parameter int BLANK_CYCLES  = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic                    started_q, started_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_d;
  scan_state_e             state_q, state_d;

  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_lz;
  logic [6:0]              dec_seg;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q;

  // All *_d values describe the cycle being entered at the next edge, so the
  // registered outputs line up with the slot position without extra latency.
  always_comb begin
    started_d = 1'b1;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (started_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    frame_d = (cnt_d == '0) && (idx_d == '0);
  end

  // Commit reads the old pending copy so a load on the commit cycle waits a frame.
  always_comb begin
    active_d     = active_q;
    active_dp_d  = active_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (frame_d && pend_valid_q) begin
      active_d     = pend_q;
      active_dp_d  = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d       = digits_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin : lz_scan
    logic seen_nz;
    lead_zero = '0;
    seen_nz   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz      = seen_nz | (active_d[4*i +: 4] != 4'h0);
      lead_zero[i] = ~seen_nz;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        cur_nib = active_d[4*i +: 4];
        cur_dp  = active_dp_d[i];
        cur_lz  = lead_zero[i];
      end
    end
  end

  hex7_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    case (state_q)
      ST_BLANK: if (cnt_d >= BLANK_END) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d == '0 && BLANK_CYCLES != 0) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
    if (state_d == ST_DRIVE) begin
      sel_d = NUM_DIGITS'(1) << idx_d;
      seg_d = (BLANK_LEADING != 0 && cur_lz) ? 7'h00 : dec_seg;
      dp_d  = cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      sel_q        <= '0;
      fs_q         <= 1'b0;
    end else begin
      started_q    <= started_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      fs_q         <= frame_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign dig_sel     = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux (4 digits, 8-cycle slots, 2 blank
// cycles); a second instance runs with leading-zero suppression disabled.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic [6:0]    seg_out, seg_out_nb;
  logic          dp_out, dp_out_nb;
  logic [3:0]    dig_sel, dig_sel_nb;
  logic          frame_start, frame_start_nb;

  int cyc;
  int total;
  int bad;

  seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel), .frame_start(frame_start)
  );

  seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .seg_out(seg_out_nb), .dp_out(dp_out_nb), .dig_sel(dig_sel_nb), .frame_start(frame_start_nb)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge; cyc names the cycle just entered.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
    load      = 1'b1;
    digits_in = d;
    dp_in     = p;
    tick();
    load      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic fs, input logic [3:0] sel,
                             input logic [6:0] seg, input logic dp);
    total++;
    assert ({frame_start, dig_sel, seg_out, dp_out} === {fs, sel, seg, dp}) else begin
      bad++;
      $error("FAIL %s cyc=%0d: observed fs=%b sel=%b seg=%h dp=%b, expected fs=%b sel=%b seg=%h dp=%b",
             tag, cyc, frame_start, dig_sel, seg_out, dp_out, fs, sel, seg, dp);
    end
  endtask

  task automatic checkOutputNb(input string tag, input logic [3:0] sel, input logic [6:0] seg);
    total++;
    assert ({dig_sel_nb, seg_out_nb} === {sel, seg}) else begin
      bad++;
      $error("FAIL %s cyc=%0d: observed sel=%b seg=%h, expected sel=%b seg=%h",
             tag, cyc, dig_sel_nb, seg_out_nb, sel, seg);
    end
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    cyc       = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reset", 1'b0, 4'b0000, 7'h00, 1'b0);
    rst = 1'b0;
    cyc = -1;
    tick();

    // Idle frame: only digit 0 shows a zero, the rest are leading-zero blanked.
    checkOutput("idle_c0", 1'b1, 4'b0000, 7'h00, 1'b0);
    runTo(1);  checkOutput("idle_c1", 1'b0, 4'b0000, 7'h00, 1'b0);
    runTo(2);  checkOutput("idle_c2", 1'b0, 4'b0001, 7'h3F, 1'b0);
    runTo(5);
    applyStimulus(16'h1A3F, 4'b0100);
    runTo(7);  checkOutput("idle_c7", 1'b0, 4'b0001, 7'h3F, 1'b0);
    runTo(8);  checkOutput("idle_c8", 1'b0, 4'b0000, 7'h00, 1'b0);
    runTo(9);  checkOutput("idle_c9", 1'b0, 4'b0000, 7'h00, 1'b0);
    runTo(10);
    checkOutput("idle_c10", 1'b0, 4'b0010, 7'h00, 1'b0);
    checkOutputNb("nb_idle_c10", 4'b0010, 7'h3F);
    runTo(18); checkOutput("idle_c18", 1'b0, 4'b0100, 7'h00, 1'b0);
    runTo(26); checkOutput("idle_c26", 1'b0, 4'b1000, 7'h00, 1'b0);
    runTo(31); checkOutput("idle_c31", 1'b0, 4'b1000, 7'h00, 1'b0);

    // Frame from 32 shows 1A3F with the decimal point on digit 2.
    runTo(32); checkOutput("ld_c32", 1'b1, 4'b0000, 7'h00, 1'b0);
    runTo(34); checkOutput("ld_d0", 1'b0, 4'b0001, 7'h71, 1'b0);
    runTo(42); checkOutput("ld_d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    runTo(50); checkOutput("ld_d2", 1'b0, 4'b0100, 7'h77, 1'b1);
    runTo(58); checkOutput("ld_d3", 1'b0, 4'b1000, 7'h06, 1'b0);
    runTo(63); checkOutput("ld_c63", 1'b0, 4'b1000, 7'h06, 1'b0);
    runTo(64); checkOutput("fs_c64", 1'b1, 4'b0000, 7'h00, 1'b0);

    // Two loads before one commit: the last one wins.
    runTo(66);
    applyStimulus(16'h1111, 4'b0000);
    runTo(74); checkOutput("hold_d1", 1'b0, 4'b0010, 7'h4F, 1'b0);
    runTo(76);
    applyStimulus(16'h2222, 4'b0000);
    runTo(98);  checkOutput("lw_d0", 1'b0, 4'b0001, 7'h5B, 1'b0);
    runTo(106); checkOutput("lw_d1", 1'b0, 4'b0010, 7'h5B, 1'b0);
    runTo(114); checkOutput("lw_d2", 1'b0, 4'b0100, 7'h5B, 1'b0);
    runTo(122); checkOutput("lw_d3", 1'b0, 4'b1000, 7'h5B, 1'b0);

    // Load on the commit cycle lands one frame later; also exercises leading zeros.
    runTo(127);
    applyStimulus(16'h0070, 4'b1000);
    runTo(130); checkOutput("cc_still_old", 1'b0, 4'b0001, 7'h5B, 1'b0);
    runTo(154); checkOutput("cc_still_old3", 1'b0, 4'b1000, 7'h5B, 1'b0);
    runTo(160); checkOutput("cc_fs160", 1'b1, 4'b0000, 7'h00, 1'b0);
    runTo(162); checkOutput("lz_d0", 1'b0, 4'b0001, 7'h3F, 1'b0);
    runTo(170); checkOutput("lz_d1", 1'b0, 4'b0010, 7'h07, 1'b0);
    runTo(178);
    checkOutput("lz_d2", 1'b0, 4'b0100, 7'h00, 1'b0);
    checkOutputNb("nb_lz_d2", 4'b0100, 7'h3F);
    runTo(186);
    checkOutput("lz_d3", 1'b0, 4'b1000, 7'h00, 1'b1);
    checkOutputNb("nb_lz_d3", 4'b1000, 7'h3F);

    // Mid-frame reset discards both the pending load and the active frame.
    runTo(200);
    applyStimulus(16'h4444, 4'b1111);
    runTo(205);
    rst = 1'b1;
    tick();
    checkOutput("rst_out", 1'b0, 4'b0000, 7'h00, 1'b0);
    rst = 1'b0;
    cyc = -1;
    tick();
    checkOutput("rst_c0", 1'b1, 4'b0000, 7'h00, 1'b0);
    runTo(2);  checkOutput("rst_c2", 1'b0, 4'b0001, 7'h3F, 1'b0);
    runTo(10); checkOutput("rst_c10", 1'b0, 4'b0010, 7'h00, 1'b0);
    runTo(32); checkOutput("rst_c32", 1'b1, 4'b0000, 7'h00, 1'b0);
    runTo(34); checkOutput("rst_c34", 1'b0, 4'b0001, 7'h3F, 1'b0);
    runTo(50); checkOutput("rst_c50", 1'b0, 4'b0100, 7'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
